serial_shift_alu: RTL
=====================

SERIAL_SHIFT_ALU -- requirements
Module: serial_shift_alu

Interface
REQ-001 The block SHALL expose the following ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- funct  input  6  ALU operation code produced by the ALU control stage.
- src1  input  32  rs operand; src1[4:0] is the SLLV shift amount.
- src2  input  32  rt operand; the value that is added, subtracted or shifted.
- shamt  input  5  instruction shift-amount field, used by SLL.
- result  output  32  registered result.
- zero  output  1  registered flag, 1 when the result being written is 0.
- busy  output  1  high while an operation is in flight (SHIFT or DONE).
- done  output  1  one-cycle pulse marking result valid.
- illegal  output  1  registered flag, 1 when the captured funct is unsupported.

REQ-002 The block SHALL use one clock; reset SHALL be synchronous and active-high.

Function
REQ-003 The block SHALL decode funct as follows:
- 6'b001001 = ADD (src1 + src2, mod 2^32, no overflow detection).
- 6'b001010 = SUB (src1 - src2, mod 2^32, no overflow detection).
- 6'b100001 = SLL (src2 << shamt).
- 6'b110101 = SLLV (src2 << src1[4:0]).
- Any other code = unsupported.

REQ-004 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.

REQ-005 When start=1 in IDLE on an edge, the block SHALL capture funct, operands and shift amount on that edge (the accept edge).

REQ-006 At the accept edge, ADD and SUB SHALL write result in one step and go to DONE.

REQ-007 At the accept edge, an unsupported funct SHALL write result=0, set illegal=1 and go to DONE.

REQ-008 At the accept edge, SLL and SLLV SHALL load result=src2 and a 5-bit counter with the shift amount, then:
- amount 0: go to DONE.
- amount not 0: go to SHIFT.

REQ-009 Each edge in SHIFT SHALL shift result left by 1 (LSB filled with 0) and decrement the counter. On the edge where the counter goes from 1 to 0, the state SHALL become DONE.

REQ-010 Latency: done SHALL be high in the cycle after edge (accept + 1 + n), where n = shift amount for shifts and n = 0 otherwise. Maximum latency is 32 cycles (shift by 31).

REQ-011 The DONE state SHALL last exactly one cycle, with done=1, then return to IDLE unconditionally.

REQ-012 busy SHALL be 1 in SHIFT and DONE, and 0 in IDLE.

REQ-013 start SHALL be ignored while busy=1; no operands are recaptured. A start coinciding with the DONE cycle is dropped.

REQ-014 result, zero and illegal SHALL hold their values in IDLE until the next accept edge.

REQ-015 zero SHALL be updated on every edge that writes result, and SHALL equal (new result == 0).

REQ-016 illegal SHALL be cleared on every accept edge of a supported funct.

REQ-017 Inputs other than start SHALL be don't-care outside the accept edge. Changes mid-operation SHALL NOT affect the result.

Reset
REQ-018 When rst=1 on an edge, the block SHALL set: state=IDLE, result=0, zero=1, busy=0, done=0, illegal=0, counter=0.

REQ-019 rst SHALL take priority over start and over every FSM transition, including mid-SHIFT and during DONE. An aborted operation SHALL produce no done pulse.

REQ-020 start=1 in the first cycle after reset is released SHALL be accepted normally.

Verification
REQ-021 ADD: src1=32'hFFFFFFFF, src2=1, start one cycle -> the next cycle shows done=1, result=0, zero=1, busy=1; the cycle after shows busy=0.

REQ-022 SUB: src1=5, src2=7 -> done after 1 cycle, result=32'hFFFFFFFE, zero=0.

REQ-023 SLL: src2=1, shamt=4 -> busy for 5 cycles, done in the 5th cycle after accept, result=32'h00000010; SLL with shamt=0 -> done after 1 cycle, result=src2.

REQ-024 SLLV: src1=32'h23 (amount 3), src2=32'h80000001 -> done 4 cycles after accept, result=32'h00000008. A second start pulsed mid-shift is ignored, and the result is unchanged.

REQ-025 Unsupported funct=6'b000000 -> done after 1 cycle, result=0, illegal=1; a following ADD 2+3 -> result=5, illegal=0.

REQ-026 SLL shamt=31 with rst asserted on the 10th cycle after accept -> the next cycle shows result=0, busy=0, done=0, and no done pulse ever appears.

Source files
------------

// File: rtl/serial_shift_alu.sv
// serial_shift_alu: multi-cycle ALU with one-step ADD/SUB and bit-serial SLL/SLLV
module serial_shift_alu (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  funct,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic [4:0]  shamt,
    output logic [31:0] result,
    output logic        zero,
    output logic        busy,
    output logic        done,
    output logic        illegal
);
    localparam logic [5:0] F_ADD  = 6'b001001;
    localparam logic [5:0] F_SUB  = 6'b001010;
    localparam logic [5:0] F_SLL  = 6'b100001;
    localparam logic [5:0] F_SLLV = 6'b110101;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] result_q, result_d;
    logic        zero_q, zero_d;
    logic        illegal_q, illegal_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] shl;
    logic [4:0]  amt;

    assign shl = result_q << 1;
    assign amt = (funct == F_SLL) ? shamt : src1[4:0];

    // next state: capture on accept, shift one bit per SHIFT cycle, single DONE cycle
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            IDLE: if (start) begin
                state_d   = DONE;
                illegal_d = 1'b0;
                case (funct)
                    F_ADD: result_d = src1 + src2;
                    F_SUB: result_d = src1 - src2;
                    F_SLL, F_SLLV: begin
                        result_d = src2;
                        cnt_d    = amt;
                        state_d  = (amt == 5'd0) ? DONE : SHIFT;
                    end
                    default: begin
                        result_d  = 32'd0;
                        illegal_d = 1'b1;
                    end
                endcase
                zero_d = (result_d == 32'd0);
            end
            SHIFT: begin
                result_d = shl;
                zero_d   = (shl == 32'd0);
                cnt_d    = cnt_q - 5'd1;
                state_d  = (cnt_q == 5'd1) ? DONE : SHIFT;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state registers; reset overrides every transition
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            result_q  <= 32'd0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
            cnt_q     <= 5'd0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    assign result  = result_q;
    assign zero    = zero_q;
    assign illegal = illegal_q;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
endmodule
